nco_wave_sequencer: RTL
=======================

Name: nco_wave_sequencer

Overview:
- Controller that drives the NCO waveform-select input (`signal_out`) and NCO enable.
- Steps through a programmable table of (select, dwell) entries and enforces a minimum hold per select, so every select change is followed by at least MIN_HOLD-1 stable cycles.
- Accepts host override requests via valid/ready.
- Sits between the host/config logic and the NCO core; NCO `wave_out` is not observed.

Parameters:
- SEL_W, 3, width of waveform select.
- DEPTH, 8, number of table entries (power of 2).
- DWELL_W, 16, width of dwell count.
- MIN_HOLD, 32, minimum cycles any select value is held (2..2^DWELL_W-1).

Ports:
- clk  in  1  clock
- resetn  in  1  asynchronous active-low reset
- cfg_we  in  1  table write strobe
- cfg_addr  in  $clog2(DEPTH)  table write index
- cfg_sel  in  SEL_W  select value to write
- cfg_dwell  in  DWELL_W  dwell cycles to write
- cfg_len  in  $clog2(DEPTH)+1  number of active entries, sampled on start
- cfg_loop  in  1  1 = wrap to entry 0 after last entry, sampled on start
- start  in  1  begin sequence (pulse)
- stop  in  1  request stop (pulse)
- req_valid  in  1  override request
- req_sel  in  SEL_W  override select
- req_ready  out  1  override accepted when req_valid & req_ready
- signal_out  out  SEL_W  select to NCO
- nco_en  out  1  NCO enable
- busy  out  1  state != IDLE
- seq_idx  out  $clog2(DEPTH)  current table entry
- done  out  1  one-cycle pulse when a non-loop sequence or stop completes

Behaviour:
- Clock and reset: single clock `clk`. Reset `resetn` is asynchronous and active-low. While low, all outputs and state clear immediately: signal_out=0, nco_en=0, busy=0, done=0, seq_idx=0, req_ready=0, state=IDLE, stop_pending=0, table entries = (sel 0, dwell 0). Reset asserted mid-run aborts with no done pulse.
- eff_dwell(d) = (d < MIN_HOLD) ? MIN_HOLD : d. A dwell of 0 is therefore MIN_HOLD. Hold counter cnt is DWELL_W bits.
- len_eff = min(cfg_len, DEPTH), latched on start together with cfg_loop.
- Table writes take effect only in IDLE; cfg_we is ignored in RUN and OVR.
- States: IDLE, RUN, OVR.
- IDLE:
  - nco_en=0; signal_out holds its last value.
  - req_ready = !start.
  - start with cfg_len != 0 -> RUN. At the same edge: seq_idx=0, signal_out=tbl[0].sel, cnt=eff_dwell(tbl[0].dwell)-1, nco_en=1.
  - start with cfg_len == 0 is ignored.
  - start and req_valid in the same cycle: start wins and the request is not accepted.
  - Accepted request -> OVR: signal_out=req_sel, cnt=MIN_HOLD-1, ret=IDLE.
  - stop is ignored.
- RUN:
  - nco_en=1; cnt decrements each cycle.
  - stop sets stop_pending; start is ignored.
  - req_ready = (cnt==0) & !stop_pending.
  - At cnt==0, in priority order:
    1. stop_pending (including stop in this same cycle): -> IDLE, nco_en=0, done=1, stop_pending=0.
    2. Request accepted: -> OVR, signal_out=req_sel, cnt=MIN_HOLD-1, ret=RUN, next index saved.
    3. Otherwise advance: next = seq_idx+1. If next == len_eff: with loop, next=0; without loop, -> IDLE with done=1, nco_en=0, signal_out unchanged. Else load tbl[next] as in start.
- OVR:
  - nco_en = 1 if ret == RUN, else 0. req_ready=0.
  - At cnt==0: if ret == IDLE -> IDLE. If ret == RUN, load the saved next entry and go to RUN; a stop received during OVR goes to IDLE with done=1 instead.
- Every load takes effect at the edge that also reloads cnt, so each select value is held exactly eff_dwell cycles (override: exactly MIN_HOLD cycles).
- Reloading the same select value is legal; there is no change on the wire.
- Single-entry loop (len_eff=1, loop=1) reloads entry 0 indefinitely.

Optional Feature:
- NCO_SEQ_PAUSE_EN defined: adds input port `pause` (1 bit). While pause=1 in RUN or OVR, cnt is frozen, signal_out and nco_en are held, and req_ready=0. stop is still latched and acts at the next cnt==0 after pause drops.
- Not defined: no pause port; cnt always decrements.

Test Plan:
- Reset: resetn=0 mid-RUN with signal_out=5 -> immediately signal_out=0, nco_en=0, busy=0, done never pulses.
- Sequence: tbl[0]=(2,40), tbl[1]=(6,10), len=2, loop=0, start -> signal_out=2 for 40 cycles, then 6 for 32 cycles (clamped), then done pulse for 1 cycle, nco_en=0, signal_out stays 6.
- Loop wrap: len=3, loop=1, dwells 32 each -> seq_idx 0,1,2,0,1 at 32-cycle intervals; no done pulse.
- Override in RUN: req_valid=1, req_sel=7 held from mid-entry 0 -> req_ready high only on the cnt==0 cycle; signal_out=7 for 32 cycles, then entry 1 loads.
- Stop: stop pulse 5 cycles into a 100-cycle dwell -> select is held the full 100 cycles, then IDLE with done=1. start with cfg_len=0 -> stays IDLE, busy=0.
- Simultaneous: start and req_valid in the same cycle in IDLE -> RUN entered, request not accepted (req_ready=0).

Source files
------------

// File: rtl/nco_seq_if.sv
// nco_seq_if: host/config and NCO-side signals of nco_wave_sequencer
//   master: host side (drives cfg_*, start, stop, req_valid, req_sel)
//   slave : sequencer side (drives req_ready, signal_out, nco_en, busy, seq_idx, done)
interface nco_seq_if #(
  parameter int SEL_W   = 3,
  parameter int DEPTH   = 8,
  parameter int DWELL_W = 16
);
  localparam int AW = $clog2(DEPTH);
  logic               cfg_we;
  logic [AW-1:0]      cfg_addr;
  logic [SEL_W-1:0]   cfg_sel;
  logic [DWELL_W-1:0] cfg_dwell;
  logic [AW:0]        cfg_len;
  logic               cfg_loop;
  logic               start;
  logic               stop;
  logic               req_valid;
  logic [SEL_W-1:0]   req_sel;
  logic               req_ready;
  logic [SEL_W-1:0]   signal_out;
  logic               nco_en;
  logic               busy;
  logic [AW-1:0]      seq_idx;
  logic               done;
  modport master (
    output cfg_we, cfg_addr, cfg_sel, cfg_dwell, cfg_len, cfg_loop, start, stop, req_valid, req_sel,
    input  req_ready, signal_out, nco_en, busy, seq_idx, done
  );
  modport slave (
    input  cfg_we, cfg_addr, cfg_sel, cfg_dwell, cfg_len, cfg_loop, start, stop, req_valid, req_sel,
    output req_ready, signal_out, nco_en, busy, seq_idx, done
  );
endinterface

// File: rtl/nco_wave_sequencer.sv
// nco_wave_sequencer: steps an NCO waveform select through a (select, dwell) table with a minimum hold per select
//   clk, resetn (async, active-low); bus: nco_seq_if.slave (table config, start/stop, override valid/ready, NCO outputs)
//   optional NCO_SEQ_PAUSE_EN: adds input pause, freezing the hold counter and override acceptance in RUN/OVR
module nco_wave_sequencer #(
  parameter int SEL_W    = 3,
  parameter int DEPTH    = 8,
  parameter int DWELL_W  = 16,
  parameter int MIN_HOLD = 32
) (
  input logic clk,
  input logic resetn,
`ifdef NCO_SEQ_PAUSE_EN
  input logic pause,
`endif
  nco_seq_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  typedef enum logic [1:0] {IDLE, RUN, OVR} state_t;
  state_t state, state_d, ret, ret_d;
  logic [SEL_W-1:0]   tbl_sel [DEPTH];
  logic [DWELL_W-1:0] tbl_dw  [DEPTH];
  logic [DWELL_W-1:0] cnt, cnt_d;
  logic [SEL_W-1:0]   sig, sig_d;
  logic [AW-1:0]      idx, idx_d, nxt, nxt_d, adv;
  logic [LW-1:0]      len, len_d, inc;
  logic en, en_d, dn, dn_d, sp, sp_d, lp, lp_d, fin, fin_d;
  logic hold, zero, rdy, acc, last;
  function automatic logic [DWELL_W-1:0] eff(input logic [DWELL_W-1:0] d);
    return d < DWELL_W'(MIN_HOLD) ? DWELL_W'(MIN_HOLD) : d;
  endfunction
`ifdef NCO_SEQ_PAUSE_EN
  assign hold = pause & (state != IDLE);
`else
  assign hold = 1'b0;
`endif
  assign zero = cnt == '0;
  assign inc  = LW'(idx) + LW'(1);
  assign last = inc == len;
  assign adv  = last ? '0 : inc[AW-1:0];
  // a stop arriving on the cnt==0 cycle wins, so the request is not offered then
  assign rdy  = resetn & ~hold & (state == IDLE ? ~bus.start : state == RUN ? zero & ~sp & ~bus.stop : 1'b0);
  assign acc  = bus.req_valid & rdy;
  assign bus.req_ready  = rdy;
  assign bus.signal_out = sig;
  assign bus.nco_en     = en;
  assign bus.busy       = state != IDLE;
  assign bus.seq_idx    = idx;
  assign bus.done       = dn;
  always_comb begin
    state_d = state;
    ret_d   = ret;
    cnt_d   = (state == IDLE || hold) ? cnt : cnt - DWELL_W'(1);
    sig_d   = sig;
    en_d    = en;
    dn_d    = 1'b0;
    sp_d    = sp;
    lp_d    = lp;
    len_d   = len;
    idx_d   = idx;
    nxt_d   = nxt;
    fin_d   = fin;
    case (state)
      IDLE: begin
        if (bus.start && bus.cfg_len != '0) begin
          state_d = RUN;
          idx_d   = '0;
          sig_d   = tbl_sel[0];
          cnt_d   = eff(tbl_dw[0]) - DWELL_W'(1);
          en_d    = 1'b1;
          len_d   = bus.cfg_len > LW'(DEPTH) ? LW'(DEPTH) : bus.cfg_len;
          lp_d    = bus.cfg_loop;
          sp_d    = 1'b0;
        end else if (acc) begin
          state_d = OVR;
          sig_d   = bus.req_sel;
          cnt_d   = DWELL_W'(MIN_HOLD - 1);
          ret_d   = IDLE;
        end
      end
      RUN: begin
        sp_d = sp | bus.stop;
        if (zero && !hold) begin
          if (sp || bus.stop) begin
            state_d = IDLE;
            en_d    = 1'b0;
            dn_d    = 1'b1;
            sp_d    = 1'b0;
          end else if (acc) begin
            // remember where to resume, and whether the sequence had already run out
            state_d = OVR;
            sig_d   = bus.req_sel;
            cnt_d   = DWELL_W'(MIN_HOLD - 1);
            ret_d   = RUN;
            nxt_d   = adv;
            fin_d   = last & ~lp;
          end else if (last && !lp) begin
            state_d = IDLE;
            en_d    = 1'b0;
            dn_d    = 1'b1;
          end else begin
            idx_d = adv;
            sig_d = tbl_sel[adv];
            cnt_d = eff(tbl_dw[adv]) - DWELL_W'(1);
          end
        end
      end
      default: begin
        if (ret == RUN) sp_d = sp | bus.stop;
        if (zero && !hold) begin
          if (ret == IDLE) begin
            state_d = IDLE;
          end else if (sp || bus.stop || fin) begin
            state_d = IDLE;
            en_d    = 1'b0;
            dn_d    = 1'b1;
            sp_d    = 1'b0;
          end else begin
            state_d = RUN;
            idx_d   = nxt;
            sig_d   = tbl_sel[nxt];
            cnt_d   = eff(tbl_dw[nxt]) - DWELL_W'(1);
          end
        end
      end
    endcase
  end
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= IDLE;
      ret   <= IDLE;
      cnt   <= '0;
      sig   <= '0;
      en    <= 1'b0;
      dn    <= 1'b0;
      sp    <= 1'b0;
      lp    <= 1'b0;
      len   <= '0;
      idx   <= '0;
      nxt   <= '0;
      fin   <= 1'b0;
    end else begin
      state <= state_d;
      ret   <= ret_d;
      cnt   <= cnt_d;
      sig   <= sig_d;
      en    <= en_d;
      dn    <= dn_d;
      sp    <= sp_d;
      lp    <= lp_d;
      len   <= len_d;
      idx   <= idx_d;
      nxt   <= nxt_d;
      fin   <= fin_d;
    end
  end
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < DEPTH; i++) begin
        tbl_sel[i] <= '0;
        tbl_dw[i]  <= '0;
      end
    end else if (bus.cfg_we && state == IDLE) begin
      tbl_sel[bus.cfg_addr] <= bus.cfg_sel;
      tbl_dw[bus.cfg_addr]  <= bus.cfg_dwell;
    end
  end
endmodule
